// File: rtl/bram_swap_unit.sv
// Dual-port BRAM access master: fetches two elements in parallel and writes
// them back exchanged for swap / compare-and-swap commands.
module bram_swap_unit #(
    parameter int AW = 18,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr_i,
    input  logic [AW-1:0] cmd_addr_j,
    input  logic [1:0]    cmd_mode,
    output logic          done,
    output logic          swapped,
    output logic [DW-1:0] rd_i,
    output logic [DW-1:0] rd_j,
    output logic          wea,
    output logic          web,
    output logic [AW-1:0] addra,
    output logic [AW-1:0] addrb,
    output logic [DW-1:0] dina,
    output logic [DW-1:0] dinb,
    input  logic [DW-1:0] douta,
    input  logic [DW-1:0] doutb
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        EVAL  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t     state_r;
    logic [1:0] mode_r;
    logic       swap_s;

    // Swap decision on the freshly read RAM words; same address never swaps so
    // both ports can never write one location in the same cycle.
    always_comb begin
        swap_s = 1'b0;
        if (addra == addrb) begin
            swap_s = 1'b0;
        end else begin
            case (mode_r)
                2'b00:   swap_s = 1'b0;
                2'b01:   swap_s = 1'b1;
                2'b10:   swap_s = (douta > doutb);
                2'b11:   swap_s = ($signed(douta) > $signed(doutb));
                default: swap_s = 1'b0;
            endcase
        end
    end

    // Command sequencer with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            mode_r    <= 2'b00;
            cmd_ready <= 1'b1;
            done      <= 1'b0;
            swapped   <= 1'b0;
            rd_i      <= {DW{1'b0}};
            rd_j      <= {DW{1'b0}};
            wea       <= 1'b0;
            web       <= 1'b0;
            addra     <= {AW{1'b0}};
            addrb     <= {AW{1'b0}};
            dina      <= {DW{1'b0}};
            dinb      <= {DW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        addra     <= cmd_addr_i;
                        addrb     <= cmd_addr_j;
                        mode_r    <= cmd_mode;
                        cmd_ready <= 1'b0;
                        state_r   <= READ;
                    end
                end
                READ: begin
                    state_r <= EVAL;
                end
                EVAL: begin
                    rd_i    <= douta;
                    rd_j    <= doutb;
                    swapped <= swap_s;
                    if (swap_s) begin
                        dina    <= doutb;
                        dinb    <= douta;
                        wea     <= 1'b1;
                        web     <= 1'b1;
                        state_r <= WRITE;
                    end else begin
                        done    <= 1'b1;
                        state_r <= DONE;
                    end
                end
                WRITE: begin
                    wea     <= 1'b0;
                    web     <= 1'b0;
                    done    <= 1'b1;
                    state_r <= DONE;
                end
                DONE: begin
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state_r   <= IDLE;
                end
                default: begin
                    wea       <= 1'b0;
                    web       <= 1'b0;
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_swap_unit.sv
// Directed bench for bram_swap_unit with a write-first dual-port RAM model.
module tb_bram_swap_unit;
    localparam int AW = 18;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr_i, cmd_addr_j;
    logic [1:0]    cmd_mode;
    logic          done, swapped;
    logic [DW-1:0] rd_i, rd_j;
    logic          wea, web;
    logic [AW-1:0] addra, addrb;
    logic [DW-1:0] dina, dinb, douta, doutb;

    logic          ld_en;
    logic [7:0]    ld_addr;
    logic [DW-1:0] ld_data;
    logic [DW-1:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bram_swap_unit #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr_i(cmd_addr_i), .cmd_addr_j(cmd_addr_j), .cmd_mode(cmd_mode),
        .done(done), .swapped(swapped), .rd_i(rd_i), .rd_j(rd_j),
        .wea(wea), .web(web), .addra(addra), .addrb(addrb),
        .dina(dina), .dinb(dinb), .douta(douta), .doutb(doutb)
    );

    // RAM model: one-cycle registered read, write-first per port, plus a preload port.
    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else begin
            if (wea) mem[addra[7:0]] <= dina;
            if (web) mem[addrb[7:0]] <= dinb;
        end
        douta <= wea ? dina : mem[addra[7:0]];
        doutb <= web ? dinb : mem[addrb[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [DW-1:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    // Issue one command from IDLE; returns cycles from accept to done and whether a write was seen.
    task automatic run_cmd(input string tag, input logic [AW-1:0] i, input logic [AW-1:0] j,
                           input logic [1:0] mode, output int lat, output bit saw_we);
        saw_we     = 1'b0;
        cmd_valid  = 1'b1;
        cmd_addr_i = i;
        cmd_addr_j = j;
        cmd_mode   = mode;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (wea || web) saw_we = 1'b1;
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    int lat;
    bit saw_we;
    int accepts;
    int done_cnt;
    bit drop_next;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr_i = '0; cmd_addr_j = '0; cmd_mode = 2'b00;
        ld_en = 1'b0; ld_addr = 8'd0; ld_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_swapped", {31'd0, swapped}, 32'd0);
        check("rst_we", {30'd0, wea, web}, 32'd0);
        check("rst_addr", {addra[15:0], addrb[15:0]}, 32'd0);
        check("rst_din", {dina, dinb}, 32'd0);
        check("rst_rd", {rd_i, rd_j}, 32'd0);
        rst = 1'b0;

        // Unsigned compare-and-swap with i > j
        load(8'd5, 16'h0010); load(8'd9, 16'h0003);
        run_cmd("cas_u", 18'd5, 18'd9, 2'b10, lat, saw_we);
        check("cas_u_lat", lat, 32'd4);
        check("cas_u_swapped", {31'd0, swapped}, 32'd1);
        check("cas_u_rd", {rd_i, rd_j}, 32'h0010_0003);
        check("cas_u_we", {31'd0, saw_we}, 32'd1);
        @(posedge clk); #1;
        check("cas_u_ram", {mem[5], mem[9]}, 32'h0003_0010);
        check("cas_u_hold", {rd_i, rd_j}, 32'h0010_0003);
        check("cas_u_idle", {31'd0, cmd_ready}, 32'd1);

        // Fetch only
        load(8'd5, 16'h0010); load(8'd9, 16'h0003);
        run_cmd("fetch", 18'd5, 18'd9, 2'b00, lat, saw_we);
        check("fetch_lat", lat, 32'd3);
        check("fetch_swapped", {31'd0, swapped}, 32'd0);
        check("fetch_we", {31'd0, saw_we}, 32'd0);
        check("fetch_rd", {rd_i, rd_j}, 32'h0010_0003);
        @(posedge clk); #1;
        check("fetch_ram", {mem[5], mem[9]}, 32'h0010_0003);

        // 0xFFFF vs 0x0001: unsigned swaps, signed does not
        load(8'd1, 16'hFFFF); load(8'd2, 16'h0001);
        run_cmd("u_ffff", 18'd1, 18'd2, 2'b10, lat, saw_we);
        check("u_ffff_swapped", {31'd0, swapped}, 32'd1);
        @(posedge clk); #1;
        check("u_ffff_ram", {mem[1], mem[2]}, 32'h0001_FFFF);
        load(8'd1, 16'hFFFF); load(8'd2, 16'h0001);
        run_cmd("s_ffff", 18'd1, 18'd2, 2'b11, lat, saw_we);
        check("s_ffff_swapped", {31'd0, swapped}, 32'd0);
        check("s_ffff_lat", lat, 32'd3);
        @(posedge clk); #1;
        check("s_ffff_ram", {mem[1], mem[2]}, 32'hFFFF_0001);

        // Signed: 5 > -32768 swaps
        load(8'd3, 16'h0005); load(8'd4, 16'h8000);
        run_cmd("s_pos", 18'd3, 18'd4, 2'b11, lat, saw_we);
        check("s_pos_swapped", {31'd0, swapped}, 32'd1);
        @(posedge clk); #1;
        check("s_pos_ram", {mem[3], mem[4]}, 32'h8000_0005);

        // Equal values: strict greater-than, no swap
        load(8'd3, 16'h0055); load(8'd4, 16'h0055);
        run_cmd("eqval", 18'd3, 18'd4, 2'b10, lat, saw_we);
        check("eqval_swapped", {31'd0, swapped}, 32'd0);
        check("eqval_we", {31'd0, saw_we}, 32'd0);
        @(posedge clk); #1;

        // Same address with unconditional swap
        load(8'd7, 16'h1234);
        run_cmd("same", 18'd7, 18'd7, 2'b01, lat, saw_we);
        check("same_lat", lat, 32'd3);
        check("same_swapped", {31'd0, swapped}, 32'd0);
        check("same_we", {31'd0, saw_we}, 32'd0);
        check("same_rd", {rd_i, rd_j}, 32'h1234_1234);
        @(posedge clk); #1;

        // Back-to-back with cmd_valid held high
        load(8'd0, 16'h00AA); load(8'd1, 16'h00BB); load(8'd2, 16'h00CC);
        accepts = 0; done_cnt = 0; drop_next = 1'b0;
        cmd_valid = 1'b1; cmd_addr_i = 18'd0; cmd_addr_j = 18'd1; cmd_mode = 2'b01;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (drop_next) cmd_valid = 1'b0;
            if (cmd_ready && cmd_valid) begin
                accepts++;
                if (accepts == 2) begin
                    check("b2b_order", done_cnt, 32'd1);
                    drop_next = 1'b1;
                end
            end
            if (done) done_cnt++;
            @(posedge clk); #1;
            if (accepts == 1) begin cmd_addr_i = 18'd1; cmd_addr_j = 18'd2; end
        end
        cmd_valid = 1'b0;
        check("b2b_accepts", accepts, 32'd2);
        check("b2b_dones", done_cnt, 32'd2);
        check("b2b_ram", {8'd0, mem[0][7:0], mem[1][7:0], mem[2][7:0]}, 32'h00BB_CCAA);

        // Reset asserted during WRITE
        load(8'd10, 16'hAAAA); load(8'd11, 16'h5555);
        cmd_valid = 1'b1; cmd_addr_i = 18'd10; cmd_addr_j = 18'd11; cmd_mode = 2'b01;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int c = 0; c < 10 && !wea; c++) begin
            @(posedge clk); #1;
        end
        check("wr_reached", {31'd0, wea}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_we", {30'd0, wea, web}, 32'd0);
        check("rst_mid_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("rst_no_done", done_cnt, 32'd0);
        @(posedge clk); #1;
        load(8'd10, 16'hAAAA); load(8'd11, 16'h5555);
        run_cmd("post_rst", 18'd10, 18'd11, 2'b01, lat, saw_we);
        check("post_rst_lat", lat, 32'd4);
        check("post_rst_swapped", {31'd0, swapped}, 32'd1);
        @(posedge clk); #1;
        check("post_rst_ram", {mem[10], mem[11]}, 32'h5555_AAAA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
